input_frame_loader: RTL and testbench

INPUT_FRAME_LOADER -- requirements
Module: input_frame_loader

---
 rtl/input_frame_loader.sv | 172 +++++++++++++++++
 tb/tb_input_frame_loader.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_frame_loader.sv
// Byte-stream frame loader: unpacks N x N pixel frames into 16-bit input SRAM
// words, each frame preceded by a header word, with a 16'hFFFF terminator.
module input_frame_loader (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        load_start,
    input  logic        load_done,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_data,
    output logic        input_sram_write_enable,
    output logic [11:0] input_sram_write_addresss,
    output logic [15:0] input_sram_write_data,
    output logic        busy,
    output logic        error,
    output logic [7:0]  frame_count
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_HDR    = 3'd1;
    localparam logic [2:0] S_PIX_HI = 3'd2;
    localparam logic [2:0] S_PIX_LO = 3'd3;
    localparam logic [2:0] S_TERM   = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [11:0] ptr_q, ptr_d;
    logic [11:0] cnt_q, cnt_d;
    logic [7:0]  held_q, held_d;
    logic        pend_q, pend_d;
    logic        we_q, we_d;
    logic [11:0] waddr_q, waddr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        busy_q, busy_d;
    logic        error_q, error_d;
    logic [7:0]  fcnt_q, fcnt_d;

    logic        rdy;
    logic        accept;
    logic [15:0] n_sq;
    logic [15:0] need;
    logic        hdr_ok;

    // Ready depends on registered state only, never on s_valid.
    assign rdy = ((state_q == S_HDR) && !pend_q)
              || (state_q == S_PIX_HI)
              || (state_q == S_PIX_LO);
    assign accept = s_valid && rdy;

    // Frame must leave room for its header, pixels and the terminator.
    // An odd N always gives an odd square, so bit 0 doubles as parity check.
    assign n_sq   = {8'd0, s_data} * {8'd0, s_data};
    assign need   = {4'd0, ptr_q} + {1'b0, n_sq[15:1]} + 16'd2;
    assign hdr_ok = !n_sq[0] && (s_data >= 8'd4) && (s_data <= 8'd64)
                 && (need <= 16'd4096);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        held_d  = held_q;
        pend_d  = pend_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        busy_d  = busy_q;
        error_d = error_q;
        fcnt_d  = fcnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (load_start) begin
                    state_d = S_HDR;
                    ptr_d   = 12'd0;
                    error_d = 1'b0;
                    fcnt_d  = 8'd0;
                    busy_d  = 1'b1;
                    pend_d  = 1'b0;
                end
            end
            S_HDR: begin
                if (pend_q) begin
                    state_d = S_TERM;
                    pend_d  = 1'b0;
                end else if (accept) begin
                    if (load_done) pend_d = 1'b1;
                    if (hdr_ok) begin
                        we_d    = 1'b1;
                        waddr_d = ptr_q;
                        wdata_d = {9'd0, s_data[6:0]};
                        ptr_d   = ptr_q + 12'd1;
                        cnt_d   = n_sq[12:1];
                        state_d = S_PIX_HI;
                    end else begin
                        error_d = 1'b1;
                    end
                end else if (load_done) begin
                    state_d = S_TERM;
                end
            end
            S_PIX_HI: begin
                if (load_done) pend_d = 1'b1;
                if (accept) begin
                    held_d  = s_data;
                    state_d = S_PIX_LO;
                end
            end
            S_PIX_LO: begin
                if (load_done) pend_d = 1'b1;
                if (accept) begin
                    we_d    = 1'b1;
                    waddr_d = ptr_q;
                    wdata_d = {held_q, s_data};
                    ptr_d   = ptr_q + 12'd1;
                    cnt_d   = cnt_q - 12'd1;
                    if (cnt_q == 12'd1) begin
                        if (fcnt_q != 8'hFF) fcnt_d = fcnt_q + 8'd1;
                        state_d = S_HDR;
                    end else begin
                        state_d = S_PIX_HI;
                    end
                end
            end
            S_TERM: begin
                we_d    = 1'b1;
                waddr_d = ptr_q;
                wdata_d = 16'hFFFF;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q <= S_IDLE;
            ptr_q   <= 12'd0;
            cnt_q   <= 12'd0;
            held_q  <= 8'd0;
            pend_q  <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= 12'd0;
            wdata_q <= 16'd0;
            busy_q  <= 1'b0;
            error_q <= 1'b0;
            fcnt_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            held_q  <= held_d;
            pend_q  <= pend_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            error_q <= error_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign s_ready                   = rdy;
    assign input_sram_write_enable   = we_q;
    assign input_sram_write_addresss = waddr_q;
    assign input_sram_write_data     = wdata_q;
    assign busy                      = busy_q;
    assign error                     = error_q;
    assign frame_count               = fcnt_q;

endmodule

// File: tb/tb_input_frame_loader.sv
// Directed bench for input_frame_loader: SRAM writes captured into a shadow
// memory and compared against hand-computed frame images.
module tb_input_frame_loader;

    logic        clk = 1'b0;
    logic        reset_b = 1'b0;
    logic        load_start = 1'b0;
    logic        load_done = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  s_data = 8'd0;
    logic        we;
    logic [11:0] waddr;
    logic [15:0] wdata;
    logic        busy;
    logic        error;
    logic [7:0]  frame_count;

    int total_cnt = 0;
    int bad_cnt = 0;
    int nwr = 0;
    int dbl = 0;
    logic prev_we = 1'b0;
    logic [15:0] mem [0:4095];

    input_frame_loader dut (
        .clk                       (clk),
        .reset_b                   (reset_b),
        .load_start                (load_start),
        .load_done                 (load_done),
        .s_valid                   (s_valid),
        .s_ready                   (s_ready),
        .s_data                    (s_data),
        .input_sram_write_enable   (we),
        .input_sram_write_addresss (waddr),
        .input_sram_write_data     (wdata),
        .busy                      (busy),
        .error                     (error),
        .frame_count               (frame_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (we) begin
            mem[waddr] = wdata;
            nwr = nwr + 1;
            if (prev_we) dbl = dbl + 1;
        end
        prev_we = we;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 4096; i++) mem[i] = 16'hDEAD;
        nwr = 0;
        dbl = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic pulse_done();
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic with_done);
        int n;
        logic r;
        n = 0;
        s_valid = 1'b1;
        s_data = b;
        load_done = with_done;
        do begin
            @(negedge clk);
            r = s_ready;
            @(posedge clk);
            #1;
            load_done = 1'b0;
            n++;
        end while (!r && n < 200);
        if (!r) chk("sready_timeout", 0, 1);
        s_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] n, input logic [7:0] base,
                              input logic gaps);
        send_byte(n, 1'b0);
        for (int i = 0; i < int'(n) * int'(n); i++) begin
            if (gaps && $urandom_range(1, 0) == 1) tick();
            send_byte(base + 8'(i), 1'b0);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 500) begin
            tick();
            n++;
        end
        if (busy) chk("busy_timeout", 1, 0);
        tick();
        tick();
    endtask

    initial begin
        logic [7:0] hi;
        logic [7:0] lo;
        clear_mem();
        #12;
        chk("rst_sready", 32'(s_ready), 0);
        chk("rst_we", 32'(we), 0);
        chk("rst_addr", 32'(waddr), 0);
        chk("rst_data", 32'(wdata), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cnt", 32'(frame_count), 0);
        reset_b = 1'b1;
        tick();
        tick();

        // single N=4 frame
        clear_mem();
        pulse_start();
        chk("t1_busy", 32'(busy), 1);
        send_frame(8'd4, 8'd1, 1'b0);
        pulse_done();
        wait_idle();
        chk("t1_hdr", 32'(mem[0]), 32'h0004);
        for (int k = 0; k < 8; k++) begin
            hi = 8'(2 * k + 1);
            lo = 8'(2 * k + 2);
            chk("t1_pix", 32'(mem[1 + k]), 32'({hi, lo}));
        end
        chk("t1_term", 32'(mem[9]), 32'hFFFF);
        chk("t1_fcnt", 32'(frame_count), 1);
        chk("t1_err", 32'(error), 0);
        chk("t1_busy_lo", 32'(busy), 0);
        chk("t1_nwr", 32'(nwr), 10);

        // N=4 then N=6
        clear_mem();
        pulse_start();
        send_frame(8'd4, 8'd1, 1'b0);
        send_frame(8'd6, 8'h40, 1'b0);
        pulse_done();
        wait_idle();
        chk("t2_hdr2", 32'(mem[9]), 32'h0006);
        for (int k = 0; k < 18; k++) begin
            hi = 8'h40 + 8'(2 * k);
            lo = 8'h41 + 8'(2 * k);
            chk("t2_pix", 32'(mem[10 + k]), 32'({hi, lo}));
        end
        chk("t2_term", 32'(mem[28]), 32'hFFFF);
        chk("t2_fcnt", 32'(frame_count), 2);
        chk("t2_nwr", 32'(nwr), 29);

        // illegal headers are consumed without writes
        clear_mem();
        pulse_start();
        send_byte(8'd5, 1'b0);
        send_byte(8'd3, 1'b0);
        send_byte(8'd66, 1'b0);
        chk("t3_nowr", 32'(nwr), 0);
        chk("t3_err_mid", 32'(error), 1);
        send_frame(8'd4, 8'd1, 1'b0);
        pulse_done();
        wait_idle();
        chk("t3_hdr", 32'(mem[0]), 32'h0004);
        chk("t3_pix8", 32'(mem[8]), 32'h0F10);
        chk("t3_term", 32'(mem[9]), 32'hFFFF);
        chk("t3_err", 32'(error), 1);
        chk("t3_nwr", 32'(nwr), 10);

        // load_done mid-frame is deferred to the frame end
        clear_mem();
        pulse_start();
        chk("t4_err_clr", 32'(error), 0);
        send_byte(8'd4, 1'b0);
        for (int i = 0; i < 6; i++) send_byte(8'(i + 1), 1'b0);
        pulse_done();
        for (int i = 6; i < 16; i++) send_byte(8'(i + 1), 1'b0);
        wait_idle();
        chk("t4_pix8", 32'(mem[8]), 32'h0F10);
        chk("t4_term", 32'(mem[9]), 32'hFFFF);
        chk("t4_fcnt", 32'(frame_count), 1);
        chk("t4_nwr", 32'(nwr), 10);

        // load_done together with the header byte
        clear_mem();
        pulse_start();
        send_byte(8'd4, 1'b1);
        for (int i = 0; i < 16; i++) send_byte(8'(i + 1), 1'b0);
        wait_idle();
        chk("t5_hdr", 32'(mem[0]), 32'h0004);
        chk("t5_term", 32'(mem[9]), 32'hFFFF);
        chk("t5_nwr", 32'(nwr), 10);

        // N=8 with random valid gaps
        clear_mem();
        pulse_start();
        send_frame(8'd8, 8'h80, 1'b1);
        pulse_done();
        wait_idle();
        chk("t6_hdr", 32'(mem[0]), 32'h0008);
        for (int k = 0; k < 32; k++) begin
            hi = 8'h80 + 8'(2 * k);
            lo = 8'h81 + 8'(2 * k);
            chk("t6_pix", 32'(mem[1 + k]), 32'({hi, lo}));
        end
        chk("t6_term", 32'(mem[33]), 32'hFFFF);
        chk("t6_nwr", 32'(nwr), 34);
        chk("t6_dbl", 32'(dbl), 0);

        // async reset mid-pixel
        clear_mem();
        pulse_start();
        send_byte(8'd4, 1'b0);
        for (int i = 0; i < 3; i++) send_byte(8'(i + 1), 1'b0);
        @(posedge clk);
        #3;
        reset_b = 1'b0;
        #1;
        chk("t7_busy", 32'(busy), 0);
        chk("t7_sready", 32'(s_ready), 0);
        chk("t7_addr", 32'(waddr), 0);
        chk("t7_data", 32'(wdata), 0);
        chk("t7_cnt", 32'(frame_count), 0);
        tick();
        tick();
        reset_b = 1'b1;
        clear_mem();
        for (int i = 0; i < 5; i++) tick();
        chk("t7_nowr", 32'(nwr), 0);
        pulse_start();
        send_frame(8'd4, 8'd1, 1'b0);
        pulse_done();
        wait_idle();
        chk("t7_hdr", 32'(mem[0]), 32'h0004);
        chk("t7_term", 32'(mem[9]), 32'hFFFF);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
